row_mask_propagate: RTL and testbench
=====================================

// Module: row_mask_propagate
// PURPOSE
//  Downstream of the start-line search stage. Takes the 512b start-row mask and propagates it row by row
//  away from the start row: each next row is read from BRAM, ANDed with the dilated previous-row mask, and
//  written back in place. Stops on an empty row, the image edge, or the row limit. Drives the top BRAM
//  rd/wr buses directly, one 32b word per transaction.
// PARAMETERS
//  P_MAX_ROWS  511  max rows processed after the start row (1..511)
//  P_DILATE    1    1: neighbour mask = m | m<<1 | m>>1 (8-connectivity); 0: neighbour mask = m
// PORTS
//  i_clk                clk  1    single clock
//  i_rstn               in   1    asynchronous active-low reset
//  i_trig               in   1    start; held high until o_done seen
//  o_done               out  1    run complete; = done_pre & i_trig
//  i_start_row_num      in   9    row already filtered by the start-line stage
//  i_512b_mask          in   512  start-row mask, bit 511 = column 0; sampled in IDLE on i_trig rise
//  i_dir                in   1    0: rows increase (start+1..511); 1: rows decrease (start-1..0)
//  o_rd_from_bram_addr  out  13   {row[8:0], word[3:0]}
//  i_rd_from_bram_data  in   32   read data, valid while i_rd_from_bram_done=1
//  o_rd_from_bram_trig  out  1    read request
//  i_rd_from_bram_done  in   1    read acknowledge
//  o_wr_to_bram_addr    out  13   {row[8:0], word[3:0]}
//  o_wr_to_bram_data    out  32   write data
//  o_wr_to_bram_trig    out  1    write request
//  i_wr_to_bram_done    in   1    write acknowledge
//  o_rows_done          out  9    rows written in the last run (includes the terminating empty row)
//  o_stop_cause         out  2    0 none, 1 empty row, 2 image edge, 3 P_MAX_ROWS
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal mask/row buffers 0. Reset mid-run aborts immediately; buses drop.
//  - Word w of a row covers bits [511-32w : 480-32w] (word 0 = MSB). Words are handled in order 0..15.
//  - BRAM handshake (rd and wr): addr/data stable and trig=1 until done=1; latch on that cycle, trig=0 next
//    cycle; the next request is issued only after done has been seen low (>=1 idle cycle between requests).
//  - FSM: IDLE -> RD_REQ <-> RD_WAIT_LOW (x16) -> CALC -> WR_REQ <-> WR_WAIT_LOW (x16) -> NEXT_ROW -> RD_REQ | DONE.
//  - IDLE: o_done_pre=0, trigs 0, o_rows_done/o_stop_cause held. On i_trig=1: latch i_512b_mask as prev,
//    clear counters, row = start+1 (dir 0) / start-1 (dir 1). If start is 511 (dir 0) / 0 (dir 1): DONE
//    directly, cause=2, rows_done=0, no BRAM access.
//  - CALC (1 cycle): new = row_data & nbr(prev); nbr per P_DILATE, shifts zero-fill at the edges (no wrap).
//  - WR: writes new (possibly all-zero) back to the same row. rows_done increments at the last word ack.
//  - NEXT_ROW: priority: new==0 -> cause 1; row at edge (511/0) -> cause 2; rows_done==P_MAX_ROWS -> cause 3;
//    any hit -> DONE, else prev=new, row +/-1, RD_REQ.
//  - DONE: o_done_pre=1; when i_trig=0 -> o_done_pre=0, IDLE next cycle.
//  - i_trig falling before DONE: run still completes (no abort); o_done stays 0 (gated); DONE leaves to IDLE.
//  - Rd and wr buses are never active in the same cycle. Per-row latency with 1-cycle acks: 16*3 + 1 + 16*3 + 1 cycles.
// TESTING
//  1. start=100, dir=0, mask bits 200..210 set, rows 101..103 same bits set, row 104 zero -> rows 101-103
//     keep bits 200..210, row 104 written 0, rows_done=4, cause=1.
//  2. P_DILATE=1, prev bit 300 only, next row bits 299 and 301 set, bit 303 set -> new row keeps 299,301
//     and clears 303; P_DILATE=0 -> new row empty.
//  3. start=511, dir=0 -> o_done after trig with zero BRAM requests, cause=2; start=1, dir=1, all-ones rows ->
//     row 0 written, rows_done=1, cause=2.
//  4. P_MAX_ROWS=3, all-ones image, start=10 -> rows 11..13 only, cause=3; row 14 never addressed.
//  5. BRAM model with random 0..5-cycle ack delay and done held 2 cycles -> addresses {row,0..15} in order,
//     trig never re-raised while done=1, results match case 1.
//  6. Assert i_rstn low during WR of word 7 -> all trigs 0 same cycle, o_done=0, new trig restarts cleanly
//     from IDLE.

Source files
------------

// File: rtl/row_mask_propagate.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// row_mask_propagate
//
// Purpose
//   Grows a 512-column start-row mask away from the start row, one row at a
//   time. Each following row is read from BRAM (16 x 32b words), ANDed with
//   the neighbourhood of the previous row's mask, and written back in place.
//   The walk stops on an all-zero result row, at the image edge (row 511 when
//   walking down, row 0 when walking up), or after P_MAX_ROWS rows.
//
// Parameters
//   P_MAX_ROWS  rows processed after the start row before stopping (1..511)
//   P_DILATE    1: neighbour mask = m | m<<1 | m>>1 (8-connectivity)
//               0: neighbour mask = m
//
// Ports
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_trig / o_done          run request (level, held until o_done) / run
//                            complete (gated by i_trig)
//   i_start_row_num          row already filtered by the start-line stage
//   i_512b_mask              start-row mask, bit 511 = column 0
//   i_dir                    0: rows increase, 1: rows decrease
//   o_rd_from_bram_*         read request bus  {row[8:0], word[3:0]}
//   i_rd_from_bram_*         read data / acknowledge
//   o_wr_to_bram_*           write request bus {row[8:0], word[3:0]}, data
//   i_wr_to_bram_done        write acknowledge
//   o_rows_done              rows written by the last run (incl. empty row)
//   o_stop_cause             0 none, 1 empty row, 2 image edge, 3 row limit
// -----------------------------------------------------------------------------
module row_mask_propagate #(
    parameter int P_MAX_ROWS = 511,
    parameter int P_DILATE   = 1
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_trig,
    output logic         o_done,
    input  logic [8:0]   i_start_row_num,
    input  logic [511:0] i_512b_mask,
    input  logic         i_dir,
    output logic [12:0]  o_rd_from_bram_addr,
    input  logic [31:0]  i_rd_from_bram_data,
    output logic         o_rd_from_bram_trig,
    input  logic         i_rd_from_bram_done,
    output logic [12:0]  o_wr_to_bram_addr,
    output logic [31:0]  o_wr_to_bram_data,
    output logic         o_wr_to_bram_trig,
    input  logic         i_wr_to_bram_done,
    output logic [8:0]   o_rows_done,
    output logic [1:0]   o_stop_cause
);

    localparam logic [8:0] MAX_ROWS_9 = 9'(P_MAX_ROWS);
    localparam logic [8:0] LAST_ROW   = 9'd511;
    localparam logic [3:0] LAST_WORD  = 4'd15;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_EMPTY = 2'd1;
    localparam logic [1:0] CAUSE_EDGE  = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT_LOW,
        S_CALC,
        S_WR_REQ,
        S_WR_WAIT_LOW,
        S_NEXT_ROW,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [8:0]   row_q, row_d;
    logic [3:0]   word_q, word_d;
    logic         dir_q, dir_d;
    logic [511:0] prev_q, prev_d;
    logic [511:0] rowbuf_q, rowbuf_d;
    logic [511:0] new_q, new_d;
    logic [8:0]   rows_done_q, rows_done_d;
    logic [1:0]   cause_q, cause_d;

    logic [8:0]   word_lsb;
    logic         start_at_edge;
    logic         row_at_edge;
    logic [8:0]   row_step;
    logic         done_pre;

    // Neighbourhood of the previous row. Plain shifts zero-fill, so the
    // outermost columns never pick up a neighbour from the other side.
    function automatic logic [511:0] nbr(input logic [511:0] m);
        if (P_DILATE != 0) begin
            return m | (m << 1) | (m >> 1);
        end else begin
            return m;
        end
    endfunction

    // Word 0 is the most significant 32 bits, so word w starts at 32*(15-w).
    assign word_lsb = {~word_q, 5'd0};

    assign start_at_edge = i_dir ? (i_start_row_num == 9'd0)
                                 : (i_start_row_num == LAST_ROW);
    assign row_at_edge   = dir_q ? (row_q == 9'd0) : (row_q == LAST_ROW);
    assign row_step      = dir_q ? (row_q - 9'd1) : (row_q + 9'd1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            word_q      <= '0;
            dir_q       <= 1'b0;
            prev_q      <= '0;
            rowbuf_q    <= '0;
            new_q       <= '0;
            rows_done_q <= '0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            word_q      <= word_d;
            dir_q       <= dir_d;
            prev_q      <= prev_d;
            rowbuf_q    <= rowbuf_d;
            new_q       <= new_d;
            rows_done_q <= rows_done_d;
            cause_q     <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        word_d      = word_q;
        dir_d       = dir_q;
        prev_d      = prev_q;
        rowbuf_d    = rowbuf_q;
        new_d       = new_q;
        rows_done_d = rows_done_q;
        cause_d     = cause_q;

        case (state_q)
            S_IDLE: begin
                if (i_trig) begin
                    dir_d       = i_dir;
                    prev_d      = i_512b_mask;
                    rows_done_d = '0;
                    cause_d     = CAUSE_NONE;
                    word_d      = '0;
                    if (start_at_edge) begin
                        // Nothing beyond the start row: finish without BRAM traffic.
                        cause_d = CAUSE_EDGE;
                        state_d = S_DONE;
                    end else begin
                        row_d   = i_dir ? (i_start_row_num - 9'd1)
                                        : (i_start_row_num + 9'd1);
                        state_d = S_RD_REQ;
                    end
                end
            end

            S_RD_REQ: begin
                if (i_rd_from_bram_done) begin
                    rowbuf_d[word_lsb +: 32] = i_rd_from_bram_data;
                    state_d                  = S_RD_WAIT_LOW;
                end
            end

            // Ack must be seen low before the next request goes out.
            S_RD_WAIT_LOW: begin
                if (!i_rd_from_bram_done) begin
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = S_CALC;
                    end else begin
                        word_d  = word_q + 4'd1;
                        state_d = S_RD_REQ;
                    end
                end
            end

            S_CALC: begin
                new_d   = rowbuf_q & nbr(prev_q);
                state_d = S_WR_REQ;
            end

            S_WR_REQ: begin
                if (i_wr_to_bram_done) begin
                    if (word_q == LAST_WORD) begin
                        rows_done_d = rows_done_q + 9'd1;
                    end
                    state_d = S_WR_WAIT_LOW;
                end
            end

            S_WR_WAIT_LOW: begin
                if (!i_wr_to_bram_done) begin
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = S_NEXT_ROW;
                    end else begin
                        word_d  = word_q + 4'd1;
                        state_d = S_WR_REQ;
                    end
                end
            end

            // Stop checks in priority order: empty row, image edge, row limit.
            S_NEXT_ROW: begin
                if (new_q == '0) begin
                    cause_d = CAUSE_EMPTY;
                    state_d = S_DONE;
                end else if (row_at_edge) begin
                    cause_d = CAUSE_EDGE;
                    state_d = S_DONE;
                end else if (rows_done_q == MAX_ROWS_9) begin
                    cause_d = CAUSE_LIMIT;
                    state_d = S_DONE;
                end else begin
                    prev_d  = new_q;
                    row_d   = row_step;
                    state_d = S_RD_REQ;
                end
            end

            S_DONE: begin
                if (!i_trig) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus drivers are decoded from the state register so a reset removes
    // both requests in the same cycle. Address/data read as zero when idle.
    assign o_rd_from_bram_trig = (state_q == S_RD_REQ);
    assign o_rd_from_bram_addr = o_rd_from_bram_trig ? {row_q, word_q} : 13'd0;

    assign o_wr_to_bram_trig   = (state_q == S_WR_REQ);
    assign o_wr_to_bram_addr   = o_wr_to_bram_trig ? {row_q, word_q} : 13'd0;
    assign o_wr_to_bram_data   = o_wr_to_bram_trig ? new_q[word_lsb +: 32] : 32'd0;

    // done_pre is held in DONE; the requester only sees it while still asking.
    assign done_pre     = (state_q == S_DONE);
    assign o_done       = done_pre & i_trig;

    assign o_rows_done  = rows_done_q;
    assign o_stop_cause = cause_q;

endmodule

// File: tb/tb_row_mask_propagate.sv
`timescale 1ns/1ps
module tb_row_mask_propagate;

    // Instance 0: P_DILATE=1, P_MAX_ROWS=511. Instance 1: P_DILATE=0, P_MAX_ROWS=3.
    logic         clk;
    logic         rstn;
    logic [1:0]   trig;
    logic [1:0]   done;
    logic [8:0]   start_row;
    logic [511:0] mask;
    logic         dir;
    logic [12:0]  rd_addr  [2];
    logic [31:0]  rd_data  [2];
    logic         rd_trig  [2];
    logic         rd_done  [2];
    logic [12:0]  wr_addr  [2];
    logic [31:0]  wr_data  [2];
    logic         wr_trig  [2];
    logic         wr_done  [2];
    logic [8:0]   rows_done[2];
    logic [1:0]   cause    [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    row_mask_propagate #(.P_MAX_ROWS(511), .P_DILATE(1)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_trig(trig[0]), .o_done(done[0]),
        .i_start_row_num(start_row), .i_512b_mask(mask), .i_dir(dir),
        .o_rd_from_bram_addr(rd_addr[0]), .i_rd_from_bram_data(rd_data[0]),
        .o_rd_from_bram_trig(rd_trig[0]), .i_rd_from_bram_done(rd_done[0]),
        .o_wr_to_bram_addr(wr_addr[0]), .o_wr_to_bram_data(wr_data[0]),
        .o_wr_to_bram_trig(wr_trig[0]), .i_wr_to_bram_done(wr_done[0]),
        .o_rows_done(rows_done[0]), .o_stop_cause(cause[0])
    );

    row_mask_propagate #(.P_MAX_ROWS(3), .P_DILATE(0)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_trig(trig[1]), .o_done(done[1]),
        .i_start_row_num(start_row), .i_512b_mask(mask), .i_dir(dir),
        .o_rd_from_bram_addr(rd_addr[1]), .i_rd_from_bram_data(rd_data[1]),
        .o_rd_from_bram_trig(rd_trig[1]), .i_rd_from_bram_done(rd_done[1]),
        .o_wr_to_bram_addr(wr_addr[1]), .o_wr_to_bram_data(wr_data[1]),
        .o_wr_to_bram_trig(wr_trig[1]), .i_wr_to_bram_done(wr_done[1]),
        .o_rows_done(rows_done[1]), .o_stop_cause(cause[1])
    );

    // ---------------- BRAM model: image source + access logs ----------------
    typedef struct {
        int          k;
        logic [12:0] addr;
        logic [31:0] data;
    } acc_t;

    logic [511:0] img [512];
    int unsigned  bram_maxdly;
    int           bram_hold;
    acc_t         rd_log[$];
    acc_t         wr_log[$];
    int           ph  [2];
    int           dly [2];
    int           hold[2];
    logic         isrd[2];

    always @(posedge clk or negedge rstn) begin
        int  d;
        bit  go;
        bit  rdsel;
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] <= 0; dly[k] <= 0; hold[k] <= 0; isrd[k] <= 1'b0;
                rd_done[k] <= 1'b0; wr_done[k] <= 1'b0; rd_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                go    = 1'b0;
                rdsel = isrd[k];
                if (ph[k] == 0 && (rd_trig[k] || wr_trig[k])) begin
                    d     = int'($urandom_range(bram_maxdly));
                    rdsel = rd_trig[k];
                    if (d == 0) go = 1'b1;
                    else begin
                        dly[k] <= d - 1; isrd[k] <= rd_trig[k]; ph[k] <= 1;
                    end
                end else if (ph[k] == 1) begin
                    if (dly[k] == 0) go = 1'b1;
                    else dly[k] <= dly[k] - 1;
                end else if (ph[k] == 2) begin
                    if (hold[k] == 0) begin
                        rd_done[k] <= 1'b0; wr_done[k] <= 1'b0; ph[k] <= 0;
                    end else hold[k] <= hold[k] - 1;
                end
                if (go) begin
                    ph[k]   <= 2;
                    hold[k] <= bram_hold - 1;
                    if (rdsel) begin
                        rd_done[k] <= 1'b1;
                        rd_data[k] <= img[rd_addr[k][12:4]][{~rd_addr[k][3:0], 5'd0} +: 32];
                        rd_log.push_back('{k, rd_addr[k], 32'd0});
                    end else begin
                        wr_done[k] <= 1'b1;
                        wr_log.push_back('{k, wr_addr[k], wr_data[k]});
                    end
                end
            end
        end
    end

    // Handshake monitor: no request while the previous ack is still high,
    // and never a read and a write request together.
    int   viol;
    logic prd_done[2];
    logic pwr_done[2];
    initial viol = 0;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_trig[k] && wr_trig[k]) viol = viol + 1;
            if (rd_trig[k] && rd_done[k] && prd_done[k]) viol = viol + 1;
            if (wr_trig[k] && wr_done[k] && pwr_done[k]) viol = viol + 1;
            prd_done[k] <= rd_done[k];
            pwr_done[k] <= wr_done[k];
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] bits(input int lo, input int hi);
        logic [511:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [511:0] rnd512(input bit dense);
        logic [511:0] v;
        for (int w = 0; w < 16; w++)
            v[w*32 +: 32] = dense ? ($urandom | $urandom) : ($urandom & $urandom & $urandom);
        return v;
    endfunction

    task automatic setup_img(input int id);
        for (int r = 0; r < 512; r++) img[r] = (id == 2) ? '1 : '0;
        if (id == 0) for (int r = 101; r <= 103; r++) img[r] = bits(200, 210);
        if (id == 1) begin
            img[51] = '0;
            img[51][299] = 1'b1; img[51][301] = 1'b1; img[51][303] = 1'b1;
        end
    endtask

    // Reference: walk rows with integer indices; leaving 0..511 is the edge.
    int           exp_rows[$];
    logic [511:0] exp_vals[$];

    function automatic void ref_run(input logic [8:0] st, input logic d, input logic [511:0] m,
                                    input bit dil, input int maxr,
                                    output int nrows, output int ecause);
        logic [511:0] prev, nb, nv;
        int r, nxt;
        exp_rows.delete(); exp_vals.delete();
        nrows = 0; ecause = 0; prev = m;
        r = d ? int'(st) - 1 : int'(st) + 1;
        if (r < 0 || r > 511) begin
            ecause = 2;
            return;
        end
        while (ecause == 0) begin
            nb = dil ? (prev | (prev << 1) | (prev >> 1)) : prev;
            nv = img[r] & nb;
            exp_rows.push_back(r); exp_vals.push_back(nv);
            nrows++;
            nxt = d ? r - 1 : r + 1;
            if (nv == '0) ecause = 1;
            else if (nxt < 0 || nxt > 511) ecause = 2;
            else if (nrows == maxr) ecause = 3;
            else begin prev = nv; r = nxt; end
        end
    endfunction

    task automatic run_once(input int k, input logic [8:0] st, input logic d, input logic [511:0] m,
                            output int lat, output bit seen);
        @(negedge clk);
        start_row = st; dir = d; mask = m; trig[k] = 1'b1;
        lat = 0; seen = 1'b0;
        while (lat < 12000 && !seen) begin
            @(posedge clk); lat++; #1;
            if (done[k]) seen = 1'b1;
        end
        @(negedge clk); trig[k] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_run(input int k, input logic [8:0] st, input logic d, input logic [511:0] m,
                             input string tag, output int lat, output logic [511:0] first);
        int rs, ws, nrows, ecause, ri, wi;
        bit seen, aok;
        logic [511:0] v;
        ref_run(st, d, m, (k == 0), (k == 0) ? 511 : 3, nrows, ecause);
        rs = rd_log.size(); ws = wr_log.size();
        run_once(k, st, d, m, lat, seen);
        check({tag, " done seen"}, seen, 1);
        check({tag, " rows_done"}, rows_done[k], nrows);
        check({tag, " cause"}, cause[k], ecause);
        check({tag, " rd count"}, rd_log.size() - rs, nrows * 16);
        check({tag, " wr count"}, wr_log.size() - ws, nrows * 16);
        first = '0;
        for (int i = 0; i < nrows; i++) begin
            aok = 1'b1; v = '0;
            for (int w = 0; w < 16; w++) begin
                ri = rs + i*16 + w; wi = ws + i*16 + w;
                if (ri >= rd_log.size() || rd_log[ri].k != k ||
                    rd_log[ri].addr != {9'(exp_rows[i]), 4'(w)}) aok = 1'b0;
                if (wi >= wr_log.size() || wr_log[wi].k != k ||
                    wr_log[wi].addr != {9'(exp_rows[i]), 4'(w)}) aok = 1'b0;
                else v[(15-w)*32 +: 32] = wr_log[wi].data;
            end
            if (i == 0) first = v;
            check($sformatf("%s row%0d addr order", tag, exp_rows[i]), aok, 1);
            check($sformatf("%s row%0d data", tag, exp_rows[i]), v, exp_vals[i]);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int           k;
        logic [8:0]   st;
        logic         d;
        logic [511:0] m;
        int           img_id;
        int           exp_rows;
        int           exp_cause;
        logic [511:0] exp_first;
        int           exp_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int           lat;
        logic [511:0] first;
        logic [511:0] m300;
        logic [511:0] f299;
        bit           got;
        logic         sdir;
        logic [8:0]   sst;

        n_checks = 0; n_pass = 0;
        rstn = 1'b0; trig = 2'b00; start_row = '0; mask = '0; dir = 1'b0;
        bram_maxdly = 0; bram_hold = 1;
        setup_img(0);

        m300 = '0; m300[300] = 1'b1;
        f299 = '0; f299[299] = 1'b1; f299[301] = 1'b1;

        // Latency with 1-cycle acks: 1 cycle to leave IDLE, then 98 per row.
        tbl[0] = '{0, 9'd100, 1'b0, bits(200, 210), 0, 4, 1, bits(200, 210), 393};
        tbl[1] = '{0, 9'd50,  1'b0, m300,           1, 2, 1, f299,           197};
        tbl[2] = '{1, 9'd50,  1'b0, m300,           1, 1, 1, '0,             99};
        tbl[3] = '{0, 9'd511, 1'b0, '1,             2, 0, 2, '0,             1};
        tbl[4] = '{0, 9'd1,   1'b1, '1,             2, 1, 2, '1,             99};
        tbl[5] = '{1, 9'd10,  1'b0, '1,             2, 3, 3, '1,             295};

        repeat (3) @(negedge clk);
        check("reset rd_trig", {rd_trig[0], rd_trig[1]}, 0);
        check("reset wr_trig", {wr_trig[0], wr_trig[1]}, 0);
        check("reset done", done, 0);
        check("reset rows/cause", {rows_done[0], cause[0], rows_done[1], cause[1]}, 0);
        check("reset buses", {rd_addr[0], wr_addr[0], wr_data[0]}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            setup_img(tbl[t].img_id);
            check_run(tbl[t].k, tbl[t].st, tbl[t].d, tbl[t].m, $sformatf("vec%0d", t), lat, first);
            check($sformatf("vec%0d rows_done", t), rows_done[tbl[t].k], tbl[t].exp_rows);
            check($sformatf("vec%0d cause", t), cause[tbl[t].k], tbl[t].exp_cause);
            check($sformatf("vec%0d latency", t), lat, tbl[t].exp_lat);
            if (tbl[t].exp_rows > 0)
                check($sformatf("vec%0d first row", t), first, tbl[t].exp_first);
        end

        // Slow BRAM: random ack delay, ack held 2 cycles; same result as vec0.
        bram_maxdly = 5; bram_hold = 2;
        setup_img(0);
        check_run(0, 9'd100, 1'b0, bits(200, 210), "slowbram", lat, first);
        check("slowbram rows_done", rows_done[0], 4);
        check("slowbram cause", cause[0], 1);
        check("slowbram first row", first, bits(200, 210));

        // Reset while word 7 of the first write is being requested.
        bram_maxdly = 0; bram_hold = 1;
        @(negedge clk);
        start_row = 9'd100; dir = 1'b0; mask = bits(200, 210); trig[0] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(posedge clk); #1;
            if (wr_trig[0] && wr_addr[0][3:0] == 4'd7) got = 1'b1;
        end
        check("midrun reached wr word7", got, 1);
        #1 rstn = 1'b0;
        #1;
        check("midrun reset trigs", {rd_trig[0], wr_trig[0]}, 0);
        check("midrun reset done", done[0], 0);
        check("midrun reset rows/cause", {rows_done[0], cause[0]}, 0);
        @(negedge clk); trig[0] = 1'b0;
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_run(0, 9'd100, 1'b0, bits(200, 210), "afterrst", lat, first);
        check("afterrst first row", first, bits(200, 210));

        // Randomised runs against the reference walk.
        for (int i = 0; i < 8; i++) begin
            bram_maxdly = 2; bram_hold = 1 + (i % 2);
            for (int r = 0; r < 512; r++) img[r] = rnd512(($urandom_range(7) != 0));
            sdir = 1'($urandom_range(1));
            sst  = sdir ? 9'($urandom_range(20)) : 9'(491 + $urandom_range(20));
            check_run(i % 2, sst, sdir, rnd512(1'b1), $sformatf("rnd%0d", i), lat, first);
        end

        check("handshake violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
